slength_decoder: RTL

- Serial decoder for the DEFLATE static (fixed-Huffman) length alphabet, symbols 256..287. It is the inverse of the static length encoder in the GZIP path.
- Consumes a bit stream through a valid/ready handshake: Huffman code bits MSB-first, then extra bits LSB-first (RFC 1951 packing).
- Outputs the reconstructed match length 3..258, an end-of-block flag, or an error flag.
- Sits in the inflate path between the bit unpacker and the LZ77 copy engine. It is invoked only when the symbol in the stream is known to be a length/EOB symbol.

---
 rtl/slength_decoder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/slength_decoder.sv
// Serial decoder for the DEFLATE fixed-Huffman length alphabet (symbols 256..287).
// Takes Huffman code bits MSB-first, then extra bits LSB-first; emits length, EOB or error.
module slength_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush_in,
    input  logic       bit_in,
    input  logic       bit_valid_in,
    output logic       bit_ready_out,
    output logic [8:0] length_out,
    output logic       eob_out,
    output logic       err_out,
    output logic       length_valid_out,
    input  logic       length_ready_in
);

    typedef enum logic [2:0] {IDLE, CODE, CODE8, EXTRA, OUT} state_t;

    typedef struct packed {
        logic [8:0] base;
        logic [2:0] nbits;
    } lut_t;

    state_t     state, state_nx;
    logic [6:0] code, code_nx;
    logic [2:0] cnt, cnt_nx;
    logic [8:0] base, base_nx;
    logic [2:0] nbits, nbits_nx;
    logic [4:0] acc, acc_nx;
    logic [2:0] k, k_nx;
    logic [8:0] len, len_nx;
    logic       eob, eob_nx;
    logic       err, err_nx;

    logic       xfer;
    logic       resolve;
    logic [4:0] idx;
    logic [7:0] c8;
    lut_t       lut;

    // idx = symbol - 257; groups of four share an extra-bit count and the
    // base steps by 2^nbits within a group, so base = ((4 + j) << nbits) + 3
    function automatic lut_t lookup(input logic [4:0] i);
        lut_t       r;
        logic [4:0] off;
        logic [2:0] g;
        off = i - 5'd8;
        g   = off[4:2];
        if (i < 5'd8) begin
            r.base  = 9'd3 + {4'd0, i};
            r.nbits = 3'd0;
        end else if (i == 5'd28) begin
            r.base  = 9'd258;
            r.nbits = 3'd0;
        end else begin
            r.base  = ({6'd0, 1'b1, off[1:0]} << (g + 3'd1)) + 9'd3;
            r.nbits = g + 3'd1;
        end
        return r;
    endfunction

    assign xfer             = bit_valid_in & bit_ready_out;
    assign bit_ready_out    = (state != OUT);
    assign length_valid_out = (state == OUT);
    assign length_out       = len;
    assign eob_out          = eob;
    assign err_out          = err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            code  <= '0;
            cnt   <= '0;
            base  <= '0;
            nbits <= '0;
            acc   <= '0;
            k     <= '0;
            len   <= '0;
            eob   <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            code  <= code_nx;
            cnt   <= cnt_nx;
            base  <= base_nx;
            nbits <= nbits_nx;
            acc   <= acc_nx;
            k     <= k_nx;
            len   <= len_nx;
            eob   <= eob_nx;
            err   <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        code_nx  = code;
        cnt_nx   = cnt;
        base_nx  = base;
        nbits_nx = nbits;
        acc_nx   = acc;
        k_nx     = k;
        len_nx   = len;
        eob_nx   = eob;
        err_nx   = err;
        resolve  = 1'b0;
        idx      = '0;
        c8       = {code, bit_in};
        lut      = lookup(idx);

        if (flush_in) begin
            state_nx = IDLE;
            code_nx  = '0;
            cnt_nx   = '0;
            base_nx  = '0;
            nbits_nx = '0;
            acc_nx   = '0;
            k_nx     = '0;
            len_nx   = '0;
            eob_nx   = 1'b0;
            err_nx   = 1'b0;
        end else begin
            case (state)
                IDLE: if (xfer) begin
                    code_nx  = {6'd0, bit_in};
                    cnt_nx   = 3'd1;
                    state_nx = CODE;
                end
                CODE: if (xfer) begin
                    code_nx = {code[5:0], bit_in};
                    cnt_nx  = cnt + 3'd1;
                    if (cnt == 3'd6) begin
                        if (code_nx == 7'd0) begin
                            eob_nx   = 1'b1;
                            len_nx   = '0;
                            state_nx = OUT;
                        end else if (code_nx <= 7'd23) begin
                            resolve = 1'b1;
                            idx     = code_nx[4:0] - 5'd1;
                        end else if (code_nx[6:2] == 5'b11000) begin
                            state_nx = CODE8;
                        end else begin
                            err_nx   = 1'b1;
                            state_nx = OUT;
                        end
                    end
                end
                CODE8: if (xfer) begin
                    if (c8[2:0] <= 3'd5) begin
                        resolve = 1'b1;
                        idx     = 5'd23 + {2'd0, c8[2:0]};
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = OUT;
                    end
                end
                EXTRA: if (xfer) begin
                    acc_nx = acc | (5'(bit_in) << k);
                    k_nx   = k + 3'd1;
                    if (k == nbits - 3'd1) begin
                        len_nx   = base + {4'd0, acc_nx};
                        state_nx = OUT;
                    end
                end
                OUT: if (length_ready_in) begin
                    len_nx   = '0;
                    eob_nx   = 1'b0;
                    err_nx   = 1'b0;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase

            if (resolve) begin
                lut = lookup(idx);
                if (lut.nbits == 3'd0) begin
                    len_nx   = lut.base;
                    state_nx = OUT;
                end else begin
                    base_nx  = lut.base;
                    nbits_nx = lut.nbits;
                    acc_nx   = '0;
                    k_nx     = '0;
                    state_nx = EXTRA;
                end
            end
        end
    end

endmodule
